// File: rtl/pwm_div_sched_pkg.sv
// Shared types for the PWM divisor scheduler: sequencer state encoding and
// the slot-table record (divisor plus repeat count).
package pwm_div_sched_pkg;

    // Storage width of one slot-table field; the top-level DW must not exceed it.
    localparam int unsigned SLOT_DW = 16;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // One divisor profile slot.
    typedef struct packed {
        logic [SLOT_DW-1:0] div;
        logic [SLOT_DW-1:0] rep;
    } slot_t;

endpackage

// File: rtl/pwm_div_sched_tbl.sv
// Divisor profile table: NUM_SLOTS register entries, one synchronous write
// port and one combinational read port. All entries clear to {0,0} on reset.
module pwm_div_sched_tbl
    import pwm_div_sched_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned AW        = $clog2(NUM_SLOTS)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  slot_t         wdata,
    input  logic [AW-1:0] raddr,
    output slot_t         rdata
);

    slot_t mem_r [NUM_SLOTS];

    // Table storage: cleared by reset, one entry written per strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // NUM_SLOTS is a power of two, so every address is a valid entry.
    assign rdata = mem_r[raddr];

endmodule

// File: rtl/pwm_div_sched.sv
// PWM divisor scheduler: steps a clock divider through a table of
// {divisor, repeat} profiles. Each slot is held for max(rep,1) divider
// toggles (tick_i); a zero divisor ends the table. Outputs are registered
// copies of the next state so they line up with the state register.
// Optional feature macro: PWM_DIV_SCHED_IRQ_EN adds a sticky irq_o that is
// set by done_o and cleared by irq_clr_i (set has priority).
module pwm_div_sched
    import pwm_div_sched_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned DW        = 16
)(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_we_i,
    input  logic [$clog2(NUM_SLOTS)-1:0] cfg_addr_i,
    input  logic [DW-1:0]                cfg_div_i,
    input  logic [DW-1:0]                cfg_rep_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    input  logic                         loop_i,
    input  logic                         tick_i,
    output logic                         div_en_o,
    output logic [DW-1:0]                divisor_o,
    output logic [$clog2(NUM_SLOTS)-1:0] slot_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
`ifdef PWM_DIV_SCHED_IRQ_EN
    ,
    input  logic                         irq_clr_i,
    output logic                         irq_o
`endif
);

    localparam int unsigned     SW        = $clog2(NUM_SLOTS);
    localparam logic [SW-1:0]   LAST_SLOT = SW'(NUM_SLOTS - 1);
    localparam logic [DW-1:0]   ONE       = {{(DW-1){1'b0}}, 1'b1};

    // A repeat count of zero behaves like a repeat count of one.
    function automatic logic [DW-1:0] rep_limit(input logic [DW-1:0] rep);
        logic [DW-1:0] lim;
        if (rep == {DW{1'b0}}) begin
            lim = ONE;
        end else begin
            lim = rep;
        end
        return lim;
    endfunction

    state_t         state_r;
    state_t         state_s;
    logic [SW-1:0]  slot_r;
    logic [SW-1:0]  slot_s;
    logic [DW-1:0]  cnt_r;
    logic [DW-1:0]  cnt_s;
    logic [DW-1:0]  divisor_r;
    logic [DW-1:0]  rep_r;
    logic           div_en_r;
    logic           busy_r;
    logic           done_r;
    logic           err_r;
    logic           err_s;
    logic           load_s;
    logic           tbl_we_s;
    logic           last_tick_s;
    slot_t          tbl_wr_s;
    slot_t          tbl_rd_s;

    assign tbl_wr_s    = '{div: SLOT_DW'(cfg_div_i), rep: SLOT_DW'(cfg_rep_i)};
    assign last_tick_s = (cnt_r == (rep_limit(rep_r) - ONE));

    // The read port follows the next slot so the entry is captured on LOAD entry.
    pwm_div_sched_tbl #(
        .NUM_SLOTS (NUM_SLOTS),
        .AW        (SW)
    ) u_tbl (
        .clk   (clk_i),
        .rst   (rst_i),
        .we    (tbl_we_s),
        .waddr (cfg_addr_i),
        .wdata (tbl_wr_s),
        .raddr (slot_s),
        .rdata (tbl_rd_s)
    );

    // Next-state, slot, tick counter, table write gating and sticky error.
    always_comb begin
        state_s  = state_r;
        slot_s   = slot_r;
        cnt_s    = cnt_r;
        err_s    = err_r;
        tbl_we_s = 1'b0;

        case (state_r)
            IDLE: begin
                tbl_we_s = cfg_we_i;
                if (start_i && !stop_i) begin
                    state_s = LOAD;
                    slot_s  = {SW{1'b0}};
                    cnt_s   = {DW{1'b0}};
                    err_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                cnt_s = {DW{1'b0}};
                if (stop_i) begin
                    state_s = FIN;
                end else if (divisor_r == {DW{1'b0}}) begin
                    state_s = FIN;
                end else begin
                    state_s = RUN;
                end
            end
            RUN: begin
                if (stop_i) begin
                    state_s = FIN;
                end else if (tick_i && last_tick_s) begin
                    cnt_s = {DW{1'b0}};
                    if (slot_r != LAST_SLOT) begin
                        state_s = LOAD;
                        slot_s  = slot_r + SW'(1'b1);
                    end else if (loop_i) begin
                        state_s = LOAD;
                        slot_s  = {SW{1'b0}};
                    end else begin
                        state_s = FIN;
                    end
                end else if (tick_i) begin
                    cnt_s = cnt_r + ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Writes while the sequence owns the table are dropped and flagged.
        if (cfg_we_i && ((state_r == LOAD) || (state_r == RUN))) begin
            err_s = 1'b1;
        end else begin
            err_s = err_s;
        end

        load_s = (state_s == LOAD);
    end

    // State, slot index, tick counter and sticky error registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            slot_r  <= {SW{1'b0}};
            cnt_r   <= {DW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            slot_r  <= slot_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
        end
    end

    // Divisor/repeat capture: only on LOAD entry, so the divider never sees a mid-period change.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            divisor_r <= {DW{1'b0}};
            rep_r     <= {DW{1'b0}};
        end else if (load_s) begin
            divisor_r <= tbl_rd_s.div[DW-1:0];
            rep_r     <= tbl_rd_s.rep[DW-1:0];
        end
    end

    // Registered status outputs decoded from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_en_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            div_en_r <= (state_s == RUN);
            busy_r   <= (state_s == LOAD) || (state_s == RUN);
            done_r   <= (state_s == FIN);
        end
    end

    assign div_en_o  = div_en_r;
    assign divisor_o = divisor_r;
    assign slot_o    = slot_r;
    assign busy_o    = busy_r;
    assign done_o    = done_r;
    assign err_o     = err_r;

`ifdef PWM_DIV_SCHED_IRQ_EN
    logic irq_r;

    // Sticky completion interrupt; a new completion beats a simultaneous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_r <= 1'b0;
        end else if (done_r) begin
            irq_r <= 1'b1;
        end else if (irq_clr_i) begin
            irq_r <= 1'b0;
        end
    end

    assign irq_o = irq_r;
`endif

endmodule

// File: tb/tb_pwm_div_sched.sv
// Directed bench for pwm_div_sched with a scoreboard queue: expectations are
// pushed as stimulus is driven and popped when the outputs are sampled.
module tb_pwm_div_sched;

    localparam int NS = 4;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [DW-1:0] cfg_div;
    logic [DW-1:0] cfg_rep;
    logic          start;
    logic          stop;
    logic          loop;
    logic          tick;
    logic          div_en;
    logic [DW-1:0] divisor;
    logic [1:0]    slot;
    logic          busy;
    logic          done;
    logic          err;
`ifdef PWM_DIV_SCHED_IRQ_EN
    logic          irq_clr;
    logic          irq;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   vectors;
    int   miscompares;

    pwm_div_sched #(.NUM_SLOTS(NS), .DW(DW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_we_i   (cfg_we),
        .cfg_addr_i (cfg_addr),
        .cfg_div_i  (cfg_div),
        .cfg_rep_i  (cfg_rep),
        .start_i    (start),
        .stop_i     (stop),
        .loop_i     (loop),
        .tick_i     (tick),
        .div_en_o   (div_en),
        .divisor_o  (divisor),
        .slot_o     (slot),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
`ifdef PWM_DIV_SCHED_IRQ_EN
        ,
        .irq_clr_i  (irq_clr),
        .irq_o      (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty observed=%0h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic exp_o(input string name, input logic b, input logic en,
                         input logic [DW-1:0] dv, input logic [1:0] sl,
                         input logic dn, input logic er);
        push({name, ".busy"},    32'(b));
        push({name, ".div_en"},  32'(en));
        push({name, ".divisor"}, 32'(dv));
        push({name, ".slot"},    32'(sl));
        push({name, ".done"},    32'(dn));
        push({name, ".err"},     32'(er));
    endtask

    task automatic chk_o();
        pop_chk(32'(busy));
        pop_chk(32'(div_en));
        pop_chk(32'(divisor));
        pop_chk(32'(slot));
        pop_chk(32'(done));
        pop_chk(32'(err));
    endtask

    task automatic wr(input logic [1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] r);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_div  = d;
        cfg_rep  = r;
        cyc();
        cfg_we   = 1'b0;
    endtask

    // Bounded wait for the completion pulse; an expired budget shows as a miscompare.
    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        push("wait_done", 32'd1);
        pop_chk(32'(done));
    endtask

    initial begin
        logic [DW-1:0] seq_div [4];
        logic [1:0]    seq_slot[4];
        seq_div  = '{16'd3, 16'd5, 16'd7, 16'd2};
        seq_slot = '{2'd1, 2'd2, 2'd3, 2'd0};
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = 2'd0;
        cfg_div  = 16'd0;
        cfg_rep  = 16'd0;
        start    = 1'b0;
        stop     = 1'b0;
        loop     = 1'b0;
        tick     = 1'b0;
`ifdef PWM_DIV_SCHED_IRQ_EN
        irq_clr  = 1'b0;
`endif

        // Reset state.
        exp_o("reset", 1'b0, 1'b0, 16'd0, 2'd0, 1'b0, 1'b0);
        cyc();
        cyc();
        chk_o();
`ifdef PWM_DIV_SCHED_IRQ_EN
        push("reset.irq", 32'd0);
        pop_chk(32'(irq));
`endif
        rst = 1'b0;
        cyc();

        // Two-slot table ending on a zero divisor.
        wr(2'd0, 16'd4, 16'd2);
        wr(2'd1, 16'd0, 16'd0);
        start = 1'b1;
        exp_o("t1_load0", 1'b1, 1'b0, 16'd4, 2'd0, 1'b0, 1'b0);
        cyc();
        start = 1'b0;
        chk_o();
        exp_o("t1_run0", 1'b1, 1'b1, 16'd4, 2'd0, 1'b0, 1'b0);
        cyc();
        chk_o();
        tick = 1'b1;
        exp_o("t1_tick1", 1'b1, 1'b1, 16'd4, 2'd0, 1'b0, 1'b0);
        cyc();
        chk_o();
        exp_o("t1_load1", 1'b1, 1'b0, 16'd0, 2'd1, 1'b0, 1'b0);
        cyc();
        tick = 1'b0;
        chk_o();
        exp_o("t1_fin", 1'b0, 1'b0, 16'd0, 2'd1, 1'b1, 1'b0);
        cyc();
        chk_o();
`ifdef PWM_DIV_SCHED_IRQ_EN
        irq_clr = 1'b1;
`endif
        exp_o("t1_idle", 1'b0, 1'b0, 16'd0, 2'd1, 1'b0, 1'b0);
        cyc();
        chk_o();
`ifdef PWM_DIV_SCHED_IRQ_EN
        irq_clr = 1'b0;
        push("irq_set_wins", 32'd1);
        pop_chk(32'(irq));
        irq_clr = 1'b1;
        cyc();
        irq_clr = 1'b0;
        push("irq_cleared", 32'd0);
        pop_chk(32'(irq));
`endif

        // Four slots, looping once then finishing after slot 3.
        wr(2'd0, 16'd2, 16'd1);
        wr(2'd1, 16'd3, 16'd1);
        wr(2'd2, 16'd5, 16'd1);
        wr(2'd3, 16'd7, 16'd1);
        loop  = 1'b1;
        start = 1'b1;
        exp_o("t2_load0", 1'b1, 1'b0, 16'd2, 2'd0, 1'b0, 1'b0);
        cyc();
        start = 1'b0;
        chk_o();
        exp_o("t2_run0", 1'b1, 1'b1, 16'd2, 2'd0, 1'b0, 1'b0);
        cyc();
        chk_o();
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1;
            exp_o("t2_loop_load", 1'b1, 1'b0, seq_div[i], seq_slot[i], 1'b0, 1'b0);
            cyc();
            tick = 1'b0;
            chk_o();
            exp_o("t2_loop_run", 1'b1, 1'b1, seq_div[i], seq_slot[i], 1'b0, 1'b0);
            cyc();
            chk_o();
        end
        loop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            exp_o("t2_last_load", 1'b1, 1'b0, seq_div[i], seq_slot[i], 1'b0, 1'b0);
            cyc();
            tick = 1'b0;
            chk_o();
            exp_o("t2_last_run", 1'b1, 1'b1, seq_div[i], seq_slot[i], 1'b0, 1'b0);
            cyc();
            chk_o();
        end
        tick = 1'b1;
        exp_o("t2_fin", 1'b0, 1'b0, 16'd7, 2'd3, 1'b1, 1'b0);
        cyc();
        tick = 1'b0;
        chk_o();
        exp_o("t2_idle", 1'b0, 1'b0, 16'd7, 2'd3, 1'b0, 1'b0);
        cyc();
        chk_o();

        // Stop coinciding with the final tick: straight to FIN, no reload.
        start = 1'b1;
        exp_o("t3_load0", 1'b1, 1'b0, 16'd2, 2'd0, 1'b0, 1'b0);
        cyc();
        start = 1'b0;
        chk_o();
        exp_o("t3_run0", 1'b1, 1'b1, 16'd2, 2'd0, 1'b0, 1'b0);
        cyc();
        chk_o();
        tick = 1'b1;
        stop = 1'b1;
        exp_o("t3_stop_fin", 1'b0, 1'b0, 16'd2, 2'd0, 1'b1, 1'b0);
        cyc();
        tick = 1'b0;
        stop = 1'b0;
        chk_o();
        exp_o("t3_idle", 1'b0, 1'b0, 16'd2, 2'd0, 1'b0, 1'b0);
        cyc();
        chk_o();
        tick = 1'b1;
        exp_o("t3_idle_tick", 1'b0, 1'b0, 16'd2, 2'd0, 1'b0, 1'b0);
        cyc();
        tick = 1'b0;
        chk_o();
        start = 1'b1;
        stop  = 1'b1;
        exp_o("t3_start_stop", 1'b0, 1'b0, 16'd2, 2'd0, 1'b0, 1'b0);
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk_o();

        // Table write during RUN is dropped and flags err until the next start.
        wr(2'd0, 16'd6, 16'd1);
        start = 1'b1;
        exp_o("t4_load0", 1'b1, 1'b0, 16'd6, 2'd0, 1'b0, 1'b0);
        cyc();
        start = 1'b0;
        chk_o();
        exp_o("t4_run0", 1'b1, 1'b1, 16'd6, 2'd0, 1'b0, 1'b0);
        cyc();
        chk_o();
        cfg_we   = 1'b1;
        cfg_addr = 2'd0;
        cfg_div  = 16'd9;
        cfg_rep  = 16'd3;
        exp_o("t4_busy_wr", 1'b1, 1'b1, 16'd6, 2'd0, 1'b0, 1'b1);
        cyc();
        cfg_we = 1'b0;
        chk_o();
        start = 1'b1;
        exp_o("t4_busy_start", 1'b1, 1'b1, 16'd6, 2'd0, 1'b0, 1'b1);
        cyc();
        start = 1'b0;
        chk_o();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        wait_done(4);
        push("t4_fin.err", 32'd1);
        pop_chk(32'(err));
        exp_o("t4_idle", 1'b0, 1'b0, 16'd6, 2'd0, 1'b0, 1'b1);
        cyc();
        chk_o();
        start = 1'b1;
        exp_o("t4_rb_load0", 1'b1, 1'b0, 16'd6, 2'd0, 1'b0, 1'b0);
        cyc();
        start = 1'b0;
        chk_o();
        exp_o("t4_rb_run0", 1'b1, 1'b1, 16'd6, 2'd0, 1'b0, 1'b0);
        cyc();
        chk_o();
        tick = 1'b1;
        exp_o("t4_rb_load1", 1'b1, 1'b0, 16'd3, 2'd1, 1'b0, 1'b0);
        cyc();
        tick = 1'b0;
        chk_o();
        stop = 1'b1;
        exp_o("t4_load_stop", 1'b0, 1'b0, 16'd3, 2'd1, 1'b1, 1'b0);
        cyc();
        stop = 1'b0;
        chk_o();
        exp_o("t4_idle2", 1'b0, 1'b0, 16'd3, 2'd1, 1'b0, 1'b0);
        cyc();
        chk_o();

        // Zero repeat advances on the first tick; then asynchronous reset mid-RUN.
        wr(2'd0, 16'd4, 16'd0);
        start = 1'b1;
        exp_o("t5_load0", 1'b1, 1'b0, 16'd4, 2'd0, 1'b0, 1'b0);
        cyc();
        start = 1'b0;
        chk_o();
        exp_o("t5_run0", 1'b1, 1'b1, 16'd4, 2'd0, 1'b0, 1'b0);
        cyc();
        chk_o();
        tick = 1'b1;
        exp_o("t5_rep0_load1", 1'b1, 1'b0, 16'd3, 2'd1, 1'b0, 1'b0);
        cyc();
        tick = 1'b0;
        chk_o();
        exp_o("t5_run1", 1'b1, 1'b1, 16'd3, 2'd1, 1'b0, 1'b0);
        cyc();
        chk_o();
        #2;
        rst = 1'b1;
        exp_o("t5_async_rst", 1'b0, 1'b0, 16'd0, 2'd0, 1'b0, 1'b0);
        #1;
        chk_o();
        for (int i = 0; i < 2; i++) begin
            exp_o("t5_in_rst", 1'b0, 1'b0, 16'd0, 2'd0, 1'b0, 1'b0);
            cyc();
            chk_o();
        end
        rst = 1'b0;
        exp_o("t5_after_rst", 1'b0, 1'b0, 16'd0, 2'd0, 1'b0, 1'b0);
        cyc();
        chk_o();

        vectors++;
        assert (sb_q.size() == 0) else begin
            miscompares++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
